// File: rtl/ring_freq_meter.sv
// ring_freq_meter: counts synchronised oscillator rising edges over a programmable
// gate window of clk cycles and latches the result with a one-cycle valid strobe.
module ring_freq_meter #(
   parameter int CNT_W       = 16,
   parameter int GATE_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              osc_in,
   input  logic [GATE_W-1:0] gate_cycles,
   input  logic              start,
   input  logic              cont,
   output logic              busy,
   output logic [CNT_W-1:0]  result,
   output logic              valid,
   output logic              overflow
);
   typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic prev_q, edge_w;
   logic [GATE_W-1:0] n_q, n_d, t_q, t_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, result_q, result_d;
   logic cont_q, cont_d, wovf_q, wovf_d, ovf_q, ovf_d, valid_q, valid_d;
   // prev tracks the synchroniser output in every state so a window never opens on a false edge
   assign edge_w = sync_q[SYNC_STAGES-1] & ~prev_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sync_q   <= '0;
         prev_q   <= 1'b0;
         n_q      <= '0;
         t_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         cont_q   <= 1'b0;
         wovf_q   <= 1'b0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], osc_in};
         prev_q   <= sync_q[SYNC_STAGES-1];
         n_q      <= n_d;
         t_q      <= t_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cont_q   <= cont_d;
         wovf_q   <= wovf_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      t_d      = t_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cont_d   = cont_q;
      wovf_d   = wovf_q;
      ovf_d    = ovf_q;
      valid_d  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = ARM;
            n_d     = (gate_cycles == '0) ? GATE_W'(1) : gate_cycles;
            cont_d  = cont;
            cnt_d   = '0;
            wovf_d  = 1'b0;
            t_d     = '0;
         end
         ARM: begin
            t_d     = (t_q == GATE_W'(1)) ? '0 : t_q + GATE_W'(1);
            state_d = (t_q == GATE_W'(1)) ? GATE : ARM;
         end
         GATE: begin
            if (edge_w) begin
               if (&cnt_q) wovf_d = 1'b1;
               else cnt_d = cnt_q + CNT_W'(1);
            end
            t_d = t_q + GATE_W'(1);
            if (t_q == n_q - GATE_W'(1)) begin
               state_d  = DONE;
               valid_d  = 1'b1;
               result_d = cnt_d;
               ovf_d    = wovf_d;
            end
         end
         DONE: begin
            state_d = cont_q ? ARM : IDLE;
            cnt_d   = '0;
            wovf_d  = 1'b0;
            t_d     = '0;
         end
         default: state_d = IDLE;
      endcase
   end
   assign busy     = (state_q != IDLE);
   assign result   = result_q;
   assign valid    = valid_q;
   assign overflow = ovf_q;
endmodule

// File: tb/tb_ring_freq_meter.sv
// tb_ring_freq_meter: directed checks of the edge-counting meter, including a
// narrow-counter instance for saturation.
module tb_ring_freq_meter;
   logic clk = 0, rst = 1, osc_in = 0, start = 0, start_s = 0, cont = 0;
   logic [15:0] gate_cycles = 0;
   logic busy, valid, overflow, busy_s, valid_s, overflow_s;
   logic [15:0] result;
   logic [3:0] result_s;
   int checks = 0, failures = 0;
   int per = 0, ph = 0, lat, p, nv;
   logic lvl = 0;

   ring_freq_meter u_dut (.clk(clk), .rst(rst), .osc_in(osc_in), .gate_cycles(gate_cycles),
      .start(start), .cont(cont), .busy(busy), .result(result), .valid(valid), .overflow(overflow));
   ring_freq_meter #(.CNT_W(4)) u_sat (.clk(clk), .rst(rst), .osc_in(osc_in), .gate_cycles(gate_cycles),
      .start(start_s), .cont(cont), .busy(busy_s), .result(result_s), .valid(valid_s), .overflow(overflow_s));

   always #5 clk = ~clk;

   // Oscillator model: square wave of period per clk cycles, or static lvl when per==0
   initial forever begin
      @(negedge clk);
      ph++;
      osc_in = (per == 0) ? lvl : ((ph % per) < per / 2);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic measure(input bit sat, input int gate, output int l);
      gate_cycles = 16'(gate);
      if (sat) start_s = 1; else start = 1;
      @(posedge clk); #1;
      start = 0; start_s = 0; l = 0;
      while (!(sat ? valid_s : valid) && l < 1000) begin
         @(posedge clk); #1; l++;
      end
   endtask

   task automatic count_valid(input int cycles, output int n);
      n = 0;
      repeat (cycles) begin
         @(posedge clk); #1;
         if (valid) n++;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_result", result, 0);
      check("rst_ovf", overflow, 0);
      rst = 0;
      // Basic: period 4, N=100
      per = 4;
      repeat (5) @(posedge clk);
      #1;
      measure(0, 100, lat);
      check("basic_lat", lat, 102);
      check("basic_result", result, 25);
      check("basic_ovf", overflow, 0);
      @(posedge clk); #1;
      check("basic_valid_1cyc", valid, 0);
      check("basic_idle", busy, 0);
      // Reset mid-GATE aborts the window
      gate_cycles = 100; start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (20) @(posedge clk);
      #1;
      check("gate_busy", busy, 1);
      rst = 1;
      @(posedge clk); #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", valid, 0);
      check("midrst_result", result, 0);
      check("midrst_ovf", overflow, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      count_valid(150, nv);
      check("midrst_no_valid", nv, 0);
      // Zero gate treated as one cycle
      per = 2;
      repeat (4) @(posedge clk);
      #1;
      measure(0, 0, lat);
      check("zero_lat", lat, 3);
      check("zero_result_range", result <= 1, 1);
      // Saturation on the 4-bit instance
      per = 4;
      repeat (4) @(posedge clk);
      #1;
      measure(1, 200, lat);
      check("sat_lat", lat, 202);
      check("sat_result", result_s, 15);
      check("sat_ovf", overflow_s, 1);
      @(posedge clk); #1;
      check("sat_ovf_hold", overflow_s, 1);
      measure(1, 20, lat);
      check("sat2_result", result_s, 5);
      check("sat2_ovf", overflow_s, 0);
      // Static low and high inputs
      per = 0; lvl = 0;
      repeat (6) @(posedge clk);
      #1;
      measure(0, 50, lat);
      check("low_lat", lat, 52);
      check("low_result", result, 0);
      check("low_ovf", overflow, 0);
      count_valid(60, nv);
      check("low_valid_once", nv, 0);
      lvl = 1;
      repeat (6) @(posedge clk);
      #1;
      measure(0, 50, lat);
      check("high_result", result, 0);
      count_valid(60, nv);
      check("high_valid_once", nv, 0);
      // Continuous mode: strobe every 13 cycles, stray starts ignored
      per = 4; cont = 1;
      repeat (4) @(posedge clk);
      #1;
      measure(0, 10, lat);
      cont = 0;
      check("cont_lat", lat, 12);
      check("cont_result0", result >= 2 && result <= 3, 1);
      for (int k = 0; k < 3; k++) begin
         p = 0;
         do begin
            @(posedge clk); #1; p++;
            start = (p == 5);
            if (p == 5) gate_cycles = 5;
         end while (!valid && p < 100);
         start = 0;
         check("cont_period", p, 13);
         check("cont_result", result >= 2 && result <= 3, 1);
         check("cont_busy", busy, 1);
      end
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      check("cont_exit_busy", busy, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
